execute_mc: RTL

Parametrised, registered successor to the single-cycle execute stage of the LEGv8 pipeline. It computes the ALU result, branch target and zero flag, and writes them into its own EX/MEM output register. It adds an iterative multi-cycle multiply op, and it supports a downstream stall and a flush. It sits between the ID/EX register and the memory stage, and asserts busy to hold upstream stages.

---
 rtl/execute_pkg.sv | 20 ++
 rtl/mul_seq.sv | 61 ++++++
 rtl/execute_mc.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/execute_pkg.sv
// Shared types and constants for the multi-cycle LEGv8 execute stage.
package execute_pkg;

   localparam int unsigned IMM_SHIFT_DEFAULT = 2;

   typedef enum logic [3:0] {
      OP_AND   = 4'b0000,
      OP_OR    = 4'b0001,
      OP_ADD   = 4'b0010,
      OP_SUB   = 4'b0110,
      OP_PASSB = 4'b0111,
      OP_MUL   = 4'b1000
   } alu_op_t;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } ex_state_t;

endpackage

// File: rtl/mul_seq.sv
// Radix-2 shift-add multiplier: consumes one bit of B per advancing edge.
module mul_seq #(
   parameter int unsigned N = 64
) (
   input  logic         clk,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic         advance_i,
   input  logic         abort_i,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic         done_c,
   output logic [N-1:0] product_c
);

   localparam int unsigned CW = $clog2(N);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  b_q, b_d;
   logic [N-1:0]  acc_q, acc_d;

   // Product including the bit consumed on the current edge.
   assign product_c = acc_q + (b_q[0] ? a_q : '0);
   assign done_c    = (cnt_q == CW'(N - 1));

   always_comb begin
      cnt_d = cnt_q;
      a_d   = a_q;
      b_d   = b_q;
      acc_d = acc_q;
      if (abort_i) begin
         cnt_d = '0;
      end else if (start_i) begin
         cnt_d = '0;
         a_d   = a_i;
         b_d   = b_i;
         acc_d = '0;
      end else if (advance_i) begin
         cnt_d = cnt_q + CW'(1);
         a_d   = a_q << 1;
         b_d   = b_q >> 1;
         acc_d = product_c;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/execute_mc.sv
// Registered LEGv8 execute stage with an iterative multiply, downstream stall and flush.
module execute_mc
   import execute_pkg::*;
#(
   parameter int unsigned N         = 64,
   parameter int unsigned IMM_SHIFT = IMM_SHIFT_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         valid_E,
   input  logic         AluSrc,
   input  logic [3:0]   AluControl,
   input  logic [N-1:0] PC_E,
   input  logic [N-1:0] signImm_E,
   input  logic [N-1:0] readData1_E,
   input  logic [N-1:0] readData2_E,
   input  logic         stall_M,
   input  logic         flush,
   output logic         busy,
   output logic         valid_M,
   output logic [N-1:0] PCBranch_M,
   output logic [N-1:0] aluResult_M,
   output logic [N-1:0] writeData_M,
   output logic         zero_M
);

   ex_state_t    state_q, state_d;
   logic         valid_m_q, valid_m_d;
   logic [N-1:0] res_q, res_d;
   logic [N-1:0] pcb_q, pcb_d;
   logic [N-1:0] wd_q, wd_d;
   logic         zero_q, zero_d;
   logic [N-1:0] pcb_lat_q, pcb_lat_d;
   logic [N-1:0] wd_lat_q, wd_lat_d;

   logic [N-1:0] op_b_c, alu_res_c, pcb_e_c, mul_prod_c;
   logic         is_mul_c, retire_c, mul_start_c, mul_adv_c, mul_done_c;

   assign op_b_c   = AluSrc ? signImm_E : readData2_E;
   assign pcb_e_c  = PC_E + (signImm_E << IMM_SHIFT);
   assign is_mul_c = (AluControl == OP_MUL);

   // Single-cycle ALU; unsupported codes (and MUL) yield zero here.
   always_comb begin
      alu_res_c = '0;
      case (AluControl)
         OP_AND:   alu_res_c = readData1_E & op_b_c;
         OP_OR:    alu_res_c = readData1_E | op_b_c;
         OP_ADD:   alu_res_c = readData1_E + op_b_c;
         OP_SUB:   alu_res_c = readData1_E - op_b_c;
         OP_PASSB: alu_res_c = op_b_c;
         default:  alu_res_c = '0;
      endcase
   end

   assign retire_c  = !stall_M && !flush &&
                      (((state_q == IDLE) && valid_E && !is_mul_c) ||
                       ((state_q == MUL) && mul_done_c));
   assign busy      = valid_E && !retire_c && !flush;
   assign mul_adv_c = (state_q == MUL) && !stall_M;

   mul_seq #(.N(N)) u_mul (
      .clk       (clk),
      .rst_ni    (reset),
      .start_i   (mul_start_c),
      .advance_i (mul_adv_c),
      .abort_i   (flush),
      .a_i       (readData1_E),
      .b_i       (op_b_c),
      .done_c    (mul_done_c),
      .product_c (mul_prod_c)
   );

   // Next state and EX/MEM register contents; flush beats stall, stall freezes all.
   always_comb begin
      state_d     = state_q;
      valid_m_d   = valid_m_q;
      res_d       = res_q;
      pcb_d       = pcb_q;
      wd_d        = wd_q;
      zero_d      = zero_q;
      pcb_lat_d   = pcb_lat_q;
      wd_lat_d    = wd_lat_q;
      mul_start_c = 1'b0;
      if (flush) begin
         state_d   = IDLE;
         valid_m_d = 1'b0;
      end else if (!stall_M) begin
         case (state_q)
            IDLE: begin
               valid_m_d = 1'b0;
               if (valid_E && is_mul_c) begin
                  mul_start_c = 1'b1;
                  pcb_lat_d   = pcb_e_c;
                  wd_lat_d    = readData2_E;
                  state_d     = MUL;
               end else if (valid_E) begin
                  valid_m_d = 1'b1;
                  res_d     = alu_res_c;
                  pcb_d     = pcb_e_c;
                  wd_d      = readData2_E;
                  zero_d    = (alu_res_c == '0);
               end
            end
            MUL: begin
               valid_m_d = 1'b0;
               if (mul_done_c) begin
                  valid_m_d = 1'b1;
                  res_d     = mul_prod_c;
                  pcb_d     = pcb_lat_q;
                  wd_d      = wd_lat_q;
                  zero_d    = (mul_prod_c == '0);
                  state_d   = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         valid_m_q <= 1'b0;
         res_q     <= '0;
         pcb_q     <= '0;
         wd_q      <= '0;
         zero_q    <= 1'b0;
         pcb_lat_q <= '0;
         wd_lat_q  <= '0;
      end else begin
         state_q   <= state_d;
         valid_m_q <= valid_m_d;
         res_q     <= res_d;
         pcb_q     <= pcb_d;
         wd_q      <= wd_d;
         zero_q    <= zero_d;
         pcb_lat_q <= pcb_lat_d;
         wd_lat_q  <= wd_lat_d;
      end
   end

   assign valid_M     = valid_m_q;
   assign aluResult_M = res_q;
   assign PCBranch_M  = pcb_q;
   assign writeData_M = wd_q;
   assign zero_M      = zero_q;

endmodule
